// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request side and decode-side
// instruction handoff, plus controller next-PC selects.
interface fetch_unit_if #(
    parameter int CNT_W = 32
);
    logic        imem_req_o;
    logic [31:0] imem_addr_o32;
    logic        imem_ready_i;
    logic [31:0] imem_rdata_i32;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o32;
    logic [31:0] pc_o32;
    logic [31:0] pc_plus4_o32;
    logic        pc_branch_i;
    logic        pc_j_i;
`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] fetch_cnt_o;
    logic [CNT_W-1:0] wait_cnt_o;

    modport master (
        output imem_req_o, imem_addr_o32,
        input  imem_ready_i, imem_rdata_i32,
        output instr_valid_o, instr_o32, pc_o32, pc_plus4_o32,
        input  instr_ready_i, pc_branch_i, pc_j_i,
        output fetch_cnt_o, wait_cnt_o
    );

    modport slave (
        input  imem_req_o, imem_addr_o32,
        output imem_ready_i, imem_rdata_i32,
        input  instr_valid_o, instr_o32, pc_o32, pc_plus4_o32,
        output instr_ready_i, pc_branch_i, pc_j_i,
        input  fetch_cnt_o, wait_cnt_o
    );
`else
    modport master (
        output imem_req_o, imem_addr_o32,
        input  imem_ready_i, imem_rdata_i32,
        output instr_valid_o, instr_o32, pc_o32, pc_plus4_o32,
        input  instr_ready_i, pc_branch_i, pc_j_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o32,
        output imem_ready_i, imem_rdata_i32,
        input  instr_valid_o, instr_o32, pc_o32, pc_plus4_o32,
        output instr_ready_i, pc_branch_i, pc_j_i
    );
`endif

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end
endinterface

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: PC, imem handshake, instruction register.
// Optional perf counters when FETCH_PERF_CNT_EN is defined.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    fetch_unit_if.master bus
);
    typedef enum logic {
        REQ,
        VALID
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] pc_plus4;
    logic [31:0] br_off;
    logic [31:0] next_pc;
    logic        take;

    assign pc_plus4 = pc_q + 32'd4;
    assign br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign take     = (state_q == VALID) && bus.instr_ready_i;

    // Jump wins over branch when the controller raises both.
    always_comb begin
        next_pc = pc_plus4;
        if (bus.pc_j_i)
            next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
        else if (bus.pc_branch_i)
            next_pc = pc_plus4 + br_off;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= REQ;
            pc_q    <= {RESET_PC[31:2], 2'b00};
            instr_q <= 32'h0;
        end else begin
            unique case (state_q)
                REQ: begin
                    if (bus.imem_ready_i) begin
                        instr_q <= bus.imem_rdata_i32;
                        state_q <= VALID;
                    end
                end
                VALID: begin
                    if (bus.instr_ready_i) begin
                        pc_q    <= {next_pc[31:2], 2'b00};
                        state_q <= REQ;
                    end
                end
            endcase
        end
    end

    // Request is masked during reset so no fetch leaks out.
    assign bus.imem_req_o    = rst_n_i && (state_q == REQ);
    assign bus.imem_addr_o32 = pc_q;
    assign bus.instr_valid_o = (state_q == VALID);
    assign bus.instr_o32     = instr_q;
    assign bus.pc_o32        = pc_q;
    assign bus.pc_plus4_o32  = pc_plus4;

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] fetch_cnt_q;
    logic [CNT_W-1:0] wait_cnt_q;
    logic             waiting;

    assign waiting = (state_q == REQ) && !bus.imem_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            fetch_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            if (take && !(&fetch_cnt_q))
                fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
            if (waiting && !(&wait_cnt_q))
                wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end
    end

    assign bus.fetch_cnt_o = fetch_cnt_q;
    assign bus.wait_cnt_o  = wait_cnt_q;
`else
    logic unused_take;
    assign unused_take = take;
`endif

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the single-cycle MIPS core. Owns the program counter, requests instructions from instruction memory over a valid/ready handshake, and holds the fetched word in an instruction register for the decode/control stage. It consumes the controller's branch-taken and jump selects to form the next PC, with branch and jump targets computed internally from the held instruction.

## Interface

- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] are ignored and forced to 0.
- CNT_W, 32, width of the performance counters. Used only when FETCH_PERF_CNT_EN is defined.

- clk_i  input  1  clock; all state updates on the rising edge.
- rst_n_i  input  1  reset; synchronous, active-low.
- imem_req_o  output  1  fetch request; address valid while high.
- imem_addr_o32  output  32  fetch address, equal to the current PC.
- imem_ready_i  input  1  memory returns data this cycle.
- imem_rdata_i32  input  32  instruction word; sampled when imem_req_o & imem_ready_i.
- instr_valid_o  output  1  instruction register holds a valid instruction.
- instr_ready_i  input  1  downstream consumes the instruction this cycle.
- instr_o32  output  32  instruction register; instr_o32[31:26] drives the controller's op_i6.
- pc_o32  output  32  PC of the held instruction.
- pc_plus4_o32  output  32  pc_o32 + 4, modulo 2^32.
- pc_branch_i  input  1  controller select: take the beq target.
- pc_j_i  input  1  controller select: take the j target.
- fetch_cnt_o  output  CNT_W  retired-fetch count. Present only with FETCH_PERF_CNT_EN.
- wait_cnt_o  output  CNT_W  memory-wait cycle count. Present only with FETCH_PERF_CNT_EN.

## Operation

- FSM states: REQ and VALID. Reset state is REQ.
- REQ:
  - imem_req_o = 1, imem_addr_o32 = PC, instr_valid_o = 0.
  - On imem_ready_i: load instr_o32 from imem_rdata_i32, go to VALID.
  - Otherwise stay in REQ, holding the address stable.
- VALID:
  - imem_req_o = 0, instr_valid_o = 1. instr_o32 and pc_o32 are stable.
  - On instr_ready_i: load PC with next_pc, go to REQ.
  - Otherwise hold all state.
- next_pc, evaluated only in VALID & instr_ready_i:
  - pc_j_i = 1: {pc_plus4[31:28], instr[25:0], 2'b00}. pc_j_i has priority over pc_branch_i.
  - else pc_branch_i = 1: pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}, modulo 2^32.
  - else: pc_plus4.
- pc_branch_i and pc_j_i are ignored in any other state or cycle.
- imem_ready_i is ignored while imem_req_o = 0, so a spurious ready does not load instr_o32.
- PC bits [1:0] are always 0.
- Arithmetic wrap-around: 0xFFFF_FFFC + 4 = 0x0000_0000. Branch targets wrap the same way.

## Timing

- Reset values: PC = {RESET_PC[31:2], 2'b00}; instr_o32 = 0; instr_valid_o = 0; imem_req_o = 1 from the first cycle after reset deasserts; counters = 0.
- While rst_n_i = 0, imem_req_o = 0.
- Reset asserted mid-operation (in REQ-wait or VALID): the same edge aborts the request and clears instr_valid_o. A late imem_ready_i in the reset cycle is dropped.
- Latency with zero-wait memory (imem_ready_i high in the request cycle): the instruction is valid in the next cycle. Peak throughput is 1 instruction per 2 cycles.
- Each memory wait cycle adds 1 cycle.
- Downstream stall (instr_ready_i = 0) holds VALID indefinitely. No new request is issued during a stall.
- The outputs pc_o32, pc_plus4_o32 and instr_o32 are registered or derived purely from registers. The next-PC path is combinational from pc_branch_i and pc_j_i into the PC register only.

## Configuration

- FETCH_PERF_CNT_EN.
  - Defined: fetch_cnt_o increments on each VALID & instr_ready_i. wait_cnt_o increments on each REQ cycle with imem_ready_i = 0. Both saturate at all-ones and reset to 0.
  - Undefined: the counter ports and logic are absent. All other behaviour is identical.

## Test plan

- Reset: RESET_PC = 32'h0040_0003, hold rst_n_i low for 3 cycles, then release. -> imem_addr_o32 = 32'h0040_0000; imem_req_o = 0 during reset and 1 on the first cycle after; instr_valid_o = 0.
- Sequential fetch: zero-wait memory, instr_ready_i = 1, no branch or jump. -> addresses 0x0, 0x4, 0x8 are requested on alternating cycles; pc_plus4_o32 tracks pc_o32 + 4.
- Branch: held instr = 32'h1000_FFFF at pc 0x100, pc_branch_i = 1. -> next address 0x100. Repeat with imm 0x0003 and pc_j_i = 0. -> next address 0x110.
- Jump priority: held instr = 32'h0800_0010 at pc 0x9000_0000, pc_j_i = 1 and pc_branch_i = 1. -> next address 0x9000_0040.
- Handshake and stalls:
  - Memory waits 3 cycles. -> address is held stable for all 4 request cycles; wait_cnt_o = 3.
  - instr_ready_i low for 5 cycles. -> instr_o32 is held and no request is issued.
  - Spurious imem_ready_i in VALID. -> no effect.
- Reset mid-wait and wrap:
  - Assert rst_n_i = 0 during REQ-wait. -> request drops on that edge.
  - PC = 0xFFFF_FFFC, sequential fetch. -> next address 0x0000_0000.
